barrel_shifter_pipe: RTL and testbench

// - Parametrised, handshaked ARM-style operand-2 shifter between the register-file B bus and the ALU B input.
// - Implements full ARM7TDMI shift semantics, including carry-out and the #0/#32 encodings (LSR/ASR #32, RRX).
// - Immediate-amount shifts take 1 cycle. Register-amount shifts take 2 cycles, modelling the extra register-read cycle.
// - Result and carry are held in an output register until the ALU accepts them.

---
 rtl/barrel_shifter_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
// ARM7TDMI-style operand-2 shifter sitting between the register-file B bus
// and the ALU B input. Immediate-amount shifts complete in one cycle;
// register-amount shifts spend an extra cycle in REG, which models the
// additional register read. Result and carry wait in an output register
// until the ALU takes them.
//
// Optional feature macro: SHIFTER_IMM_ROT_EN
//   When defined, imm_rot=1 on an immediate command selects the
//   data-processing immediate form: b_bus[7:0] rotated right by 2*imm[3:0].
//   When undefined, imm_rot is ignored and no rotate-immediate logic exists.

module barrel_shifter_pipe #(
   parameter int DATA_W    = 32,
   parameter int REG_AMT_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         b_bus,
   input  logic                      carry_in,
   input  logic [1:0]                shift_type,
   input  logic [$clog2(DATA_W)-1:0] shift_amount_imm,
   input  logic [REG_AMT_W-1:0]      shift_amount_reg,
   input  logic                      reg_shift,
   input  logic                      imm_rot,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         alu_input,
   output logic                      carry_out
);

   localparam int SA_W = $clog2(DATA_W);
   localparam logic [REG_AMT_W-1:0] W_AMT = REG_AMT_W'(DATA_W);

   typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_REG = 1'b1} state_t;

   state_t state_q, state_d;

   logic                 accept;
   logic [DATA_W-1:0]    cap_b;
   logic                 cap_c;
   shift_t               cap_type;
   logic [REG_AMT_W-1:0] cap_amt;

   logic                 load;
   logic [DATA_W-1:0]    sel_b;
   logic                 sel_c;
   shift_t               sel_type;
   logic [REG_AMT_W-1:0] sel_amt;
   logic                 sel_rrx;
   logic [DATA_W:0]      shift_res;   // {carry, result}

   // Register-amount semantics on the full amount; immediate encodings are
   // mapped onto this before the call (LSR/ASR #0 -> #W). Each shift is done
   // one bit wider than the operand so the carry comes out of the same shift.
   function automatic logic [DATA_W:0] shift_core(
      input logic [DATA_W-1:0]    b,
      input logic                 c,
      input shift_t               t,
      input logic [REG_AMT_W-1:0] n
   );
      logic [DATA_W:0]   ext;
      logic [DATA_W-1:0] rot;
      logic [SA_W-1:0]   s;
      s = n[SA_W-1:0];
      shift_core = {c, b};
      if (n != '0) begin
         unique case (t)
            SH_LSL: begin
               if (n < W_AMT) begin
                  ext = {1'b0, b} << s;
                  shift_core = ext;
               end else if (n == W_AMT) begin
                  shift_core = {b[0], {DATA_W{1'b0}}};
               end else begin
                  shift_core = '0;
               end
            end
            SH_LSR: begin
               if (n < W_AMT) begin
                  ext = {b, 1'b0} >> s;
                  shift_core = {ext[0], ext[DATA_W:1]};
               end else if (n == W_AMT) begin
                  shift_core = {b[DATA_W-1], {DATA_W{1'b0}}};
               end else begin
                  shift_core = '0;
               end
            end
            SH_ASR: begin
               if (n < W_AMT) begin
                  ext = $unsigned($signed({b, 1'b0}) >>> s);
                  shift_core = {ext[0], ext[DATA_W:1]};
               end else begin
                  shift_core = {(DATA_W+1){b[DATA_W-1]}};
               end
            end
            default: begin
               // Rotate by N mod W; a multiple of W leaves b with carry b[W-1],
               // which the rotate itself yields because b << W is zero.
               rot = (b >> s) | (b << (DATA_W - int'(s)));
               shift_core = {rot[DATA_W-1], rot};
            end
         endcase
      end
   endfunction

`ifdef SHIFTER_IMM_ROT_EN
   // Data-processing immediate: 8-bit value rotated right by twice the field.
   function automatic logic [DATA_W:0] rot_imm(
      input logic [DATA_W-1:0] b,
      input logic              c,
      input logic [SA_W-1:0]   amt
   );
      int                rs;
      logic [DATA_W-1:0] v;
      logic [DATA_W-1:0] r;
      rs = (2 * (int'(amt) % 16)) % DATA_W;
      v  = DATA_W'(b[7:0]);
      r  = (v >> rs) | (v << (DATA_W - rs));
      rot_imm = {(rs == 0) ? c : r[DATA_W-1], r};
   endfunction
`else
   logic unused_imm_rot;
   assign unused_imm_rot = imm_rot;
`endif

   // Handshake: only IDLE with a free (or draining) output register accepts.
   assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign load     = (accept && !reg_shift) || (state_q == ST_REG);

   // Operand select: captured command in REG, live inputs otherwise.
   always_comb begin
      sel_b    = b_bus;
      sel_c    = carry_in;
      sel_type = shift_t'(shift_type);
      sel_amt  = REG_AMT_W'(shift_amount_imm);
      sel_rrx  = 1'b0;
      if (state_q == ST_REG) begin
         sel_b    = cap_b;
         sel_c    = cap_c;
         sel_type = cap_type;
         sel_amt  = cap_amt;
      end else if (reg_shift) begin
         sel_amt = shift_amount_reg;
      end else if (shift_amount_imm == '0) begin
         if (sel_type == SH_LSR || sel_type == SH_ASR) sel_amt = W_AMT;
         if (sel_type == SH_ROR) sel_rrx = 1'b1;
      end
   end

   // Shift result, with RRX and the optional rotate-immediate overriding it.
   always_comb begin
      if (sel_rrx) begin
         shift_res = {sel_b[0], sel_c, sel_b[DATA_W-1:1]};
      end else begin
         shift_res = shift_core(sel_b, sel_c, sel_type, sel_amt);
      end
`ifdef SHIFTER_IMM_ROT_EN
      if (state_q == ST_IDLE && !reg_shift && imm_rot) begin
         shift_res = rot_imm(b_bus, carry_in, shift_amount_imm);
      end
`endif
   end

   // Next-state logic: a register-amount accept spends exactly one cycle in REG.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept && reg_shift) state_d = ST_REG;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset returns to IDLE and drops any pending register shift.
   // NOTE: sequential logic uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Capture the command for the second cycle of a register-amount shift.
   // NOTE: these datapath flops are deliberately not reset; they are only read in REG, which reset leaves.
   always_ff @(posedge clk) begin
      if (accept && reg_shift) begin
         cap_b    <= b_bus;
         cap_c    <= carry_in;
         cap_type <= shift_t'(shift_type);
         cap_amt  <= shift_amount_reg;
      end
   end

   // Output register: load a new result, otherwise hold until the ALU takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_input <= '0;
         carry_out <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         alu_input <= shift_res[DATA_W-1:0];
         carry_out <= shift_res[DATA_W];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe
// Directed vector table for the shift semantics plus hand-written sequences
// for reset, backpressure, REG/imm ordering and reset during REG.

module tb_barrel_shifter_pipe;

   localparam int DATA_W    = 32;
   localparam int REG_AMT_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       b_bus;
   logic              carry_in;
   logic [1:0]        shift_type;
   logic [4:0]        shift_amount_imm;
   logic [7:0]        shift_amount_reg;
   logic              reg_shift;
   logic              imm_rot;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       alu_input;
   logic              carry_out;

   int checks = 0;
   int errors = 0;

   barrel_shifter_pipe #(.DATA_W(DATA_W), .REG_AMT_W(REG_AMT_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .b_bus            (b_bus),
      .carry_in         (carry_in),
      .shift_type       (shift_type),
      .shift_amount_imm (shift_amount_imm),
      .shift_amount_reg (shift_amount_reg),
      .reg_shift        (reg_shift),
      .imm_rot          (imm_rot),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .alu_input        (alu_input),
      .carry_out        (carry_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      bit          rs;
      bit [1:0]    st;
      logic [4:0]  imm;
      logic [7:0]  amt;
      logic [31:0] b;
      bit          c;
      bit          irot;
      logic [31:0] exp_r;
      bit          exp_c;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input bit rs, input bit [1:0] st, input logic [4:0] imm,
                        input logic [7:0] amt, input logic [31:0] b, input bit c, input bit irot);
      in_valid         = 1'b1;
      reg_shift        = rs;
      shift_type       = st;
      shift_amount_imm = imm;
      shift_amount_reg = amt;
      b_bus            = b;
      carry_in         = c;
      imm_rot          = irot;
   endtask

   // Apply one vector with out_ready=1 and check result, carry and latency.
   task automatic run_vec(input vec_t v);
      int wait_cyc;
      int lat;
      @(negedge clk);
      drive(v.rs, v.st, v.imm, v.amt, v.b, v.c, v.irot);
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      check({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      check({v.name, " latency"}, lat, v.rs ? 32'd2 : 32'd1);
      check({v.name, " result"}, alu_input, v.exp_r);
      check({v.name, " carry"}, {31'b0, carry_out}, {31'b0, v.exp_c});
   endtask

   initial begin
      //          name          rs st     imm   amt   b             c  irot exp_r         exp_c
      vecs.push_back('{"imm_lsr0",  0, 2'b01, 5'd0, 8'd0,   32'h8000_0001, 0, 0, 32'h0000_0000, 1});
      vecs.push_back('{"imm_rrx",   0, 2'b11, 5'd0, 8'd0,   32'h0000_0003, 1, 0, 32'h8000_0001, 1});
      vecs.push_back('{"imm_lsl0",  0, 2'b00, 5'd0, 8'd0,   32'h1234_5678, 1, 0, 32'h1234_5678, 1});
      vecs.push_back('{"imm_lsl4",  0, 2'b00, 5'd4, 8'd0,   32'hF000_0001, 0, 0, 32'h0000_0010, 1});
      vecs.push_back('{"imm_lsr8",  0, 2'b01, 5'd8, 8'd0,   32'h0000_01FF, 0, 0, 32'h0000_0001, 1});
      vecs.push_back('{"imm_asr0",  0, 2'b10, 5'd0, 8'd0,   32'h8000_0000, 0, 0, 32'hFFFF_FFFF, 1});
      vecs.push_back('{"imm_asr4",  0, 2'b10, 5'd4, 8'd0,   32'h8000_0010, 1, 0, 32'hF800_0001, 0});
      vecs.push_back('{"imm_ror8",  0, 2'b11, 5'd8, 8'd0,   32'h1234_5678, 1, 0, 32'h7812_3456, 0});
      vecs.push_back('{"reg_lsl32", 1, 2'b00, 5'd0, 8'd32,  32'h0000_0001, 0, 0, 32'h0000_0000, 1});
      vecs.push_back('{"reg_ror64", 1, 2'b11, 5'd0, 8'd64,  32'h8000_0000, 0, 0, 32'h8000_0000, 1});
      vecs.push_back('{"reg_zero",  1, 2'b01, 5'd7, 8'd0,   32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1});
      vecs.push_back('{"reg_lsl33", 1, 2'b00, 5'd0, 8'd33,  32'hFFFF_FFFF, 1, 0, 32'h0000_0000, 0});
      vecs.push_back('{"reg_lsr32", 1, 2'b01, 5'd0, 8'd32,  32'h8000_0000, 0, 0, 32'h0000_0000, 1});
      vecs.push_back('{"reg_asr200",1, 2'b10, 5'd0, 8'd200, 32'h7FFF_FFFF, 1, 0, 32'h0000_0000, 0});
      vecs.push_back('{"reg_ror36", 1, 2'b11, 5'd0, 8'd36,  32'h0000_001F, 0, 0, 32'hF000_0001, 1});
      vecs.push_back('{"reg_lsr1",  1, 2'b01, 5'd0, 8'd1,   32'h0000_0003, 0, 0, 32'h0000_0001, 1});
`ifdef SHIFTER_IMM_ROT_EN
      vecs.push_back('{"imm_rot",   0, 2'b00, 5'd4, 8'd0,   32'h0000_00FF, 0, 1, 32'hFF00_0000, 1});
`else
      vecs.push_back('{"imm_rot_off",0,2'b00, 5'd4, 8'd0,   32'h0000_00FF, 0, 1, 32'h0000_0FF0, 0});
`endif

      // Reset with a command presented.
      rst_n = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 2'b00, 5'd1, 8'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("rst in_ready", {31'b0, in_ready}, 32'd0);
      check("rst out_valid", {31'b0, out_valid}, 32'd0);
      check("rst alu_input", alu_input, 32'd0);
      check("rst carry_out", {31'b0, carry_out}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post-rst out_valid", {31'b0, out_valid}, 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);
      @(negedge clk);
      check("drain out_valid", {31'b0, out_valid}, 32'd0);

      // Backpressure: first result held, second command stalled then accepted.
      out_ready = 1'b0;
      drive(1'b0, 2'b00, 5'd1, 8'd0, 32'h0000_0001, 1'b0, 1'b0);   // LSL #1 -> 2
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 2'b01, 5'd1, 8'd0, 32'h0000_0002, 1'b0, 1'b0);   // LSR #1 -> 1
      for (int k = 0; k < 3; k++) begin
         check("bp out_valid", {31'b0, out_valid}, 32'd1);
         check("bp in_ready", {31'b0, in_ready}, 32'd0);
         check("bp held", alu_input, 32'h0000_0002);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp second valid", {31'b0, out_valid}, 32'd1);
      check("bp second data", alu_input, 32'h0000_0001);
      @(negedge clk);
      check("bp no duplicate", {31'b0, out_valid}, 32'd0);

      // Register shift followed immediately by an immediate shift.
      drive(1'b1, 2'b00, 5'd0, 8'd4, 32'h0000_0001, 1'b0, 1'b0);   // LSL Rs=4 -> 0x10
      @(posedge clk);
      @(negedge clk);
      check("reg->imm in_ready in REG", {31'b0, in_ready}, 32'd0);
      check("reg->imm not yet valid", {31'b0, out_valid}, 32'd0);
      drive(1'b0, 2'b01, 5'd4, 8'd0, 32'h0000_0F00, 1'b0, 1'b0);   // LSR #4 -> 0xF0
      @(posedge clk);
      @(negedge clk);
      check("reg->imm first valid", {31'b0, out_valid}, 32'd1);
      check("reg->imm first data", alu_input, 32'h0000_0010);
      check("reg->imm ready again", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("reg->imm second valid", {31'b0, out_valid}, 32'd1);
      check("reg->imm second data", alu_input, 32'h0000_00F0);
      @(negedge clk);
      check("reg->imm drained", {31'b0, out_valid}, 32'd0);

      // Reset while in REG aborts the pending result.
      drive(1'b1, 2'b00, 5'd0, 8'd1, 32'h0000_0001, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst-in-REG in_ready", {31'b0, in_ready}, 32'd0);
      check("rst-in-REG out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("rst-in-REG no result", {31'b0, out_valid}, 32'd0);
      end
      check("rst-in-REG ready", {31'b0, in_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
